ex16b_unit: RTL
===============

// Module: ex16b_unit
// PURPOSE
//  Execute stage of the 16-bit, 4-register datapath. Consumes opA/opB read from the register file.
//  Computes ALU/shift results and an optional iterative multiply.
//  Drives the register-file write port (data/rd/en) as the writeback stage, plus Z/C flags.
//  Single-cycle ops sustain 1 op/cycle. MUL stalls the front end via in_ready.
// PARAMETERS
//  WIDTH     16  datapath width (opA/opB/result)
//  RDW        2  destination register index width
//  MUL_ITERS 16  multiply iterations (must equal WIDTH)
// PORTS
//  clk       in     1      rising-edge clock
//  rst       in     1      synchronous reset, active-high
//  in_valid  in     1      operation presented this cycle
//  in_ready  out    1      stage can accept; accept = in_valid & in_ready
//  op        in     3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
//  opA       in     WIDTH  operand A from RF
//  opB       in     WIDTH  operand B from RF
//  rd        in     RDW    destination register
//  wb_en     out    1      RF write enable, one-cycle pulse per result
//  wb_rd     out    RDW    RF write index
//  wb_data   out    WIDTH  RF write data
//  flag_z    out    1      result==0, updated on each wb_en
//  flag_c    out    1      carry/borrow/shift-out, updated on each wb_en
//  busy      out    1      multiply in progress
//  dvdd,dgnd inout  1      supply pins, no logic
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1 (deasserts during rst), wb_en=0, wb_rd=0, wb_data=0, flags=0, busy=0.
//  - FSM IDLE/MUL. in_ready = (state==IDLE) & !rst. in_valid while busy is not accepted; upstream holds.
//  - Single-cycle op accepted in cycle N -> wb_en=1 with wb_rd/wb_data/flags valid in cycle N+1.
//    Back-to-back accepts give one wb_en per cycle.
//  - ADD: {C,res}=A+B (17-bit). SUB: res=A-B, C=1 iff A<B unsigned (borrow).
//  - AND/OR/XOR: C=0.
//  - SHL/SHR are logical, count = opB[3:0]. C = last bit shifted out; C=0 when count=0.
//  - MUL (low WIDTH bits of A*B, shift-add): accept in N -> IDLE->MUL, busy=1, in_ready=0 for cycles N+1..N+16.
//    The last iteration edge loads the wb regs and returns to IDLE: wb_en in N+17, in_ready=1 in N+17. C=0.
//  - wb_en low: wb_rd/wb_data hold their last values; flags hold.
//  - rst mid-MUL: abort. No writeback, partial product discarded, IDLE next cycle.
//  - No internal forwarding. The issuing stage must not read a rd whose wb_en is still pending.
// CONFIGURATION
//  Macro EX16B_MUL_EN:
//  - Defined: MUL as above, ex16b_mul_seq instantiated.
//  - Undefined: no multiplier hardware, FSM never leaves IDLE, busy tied 0.
//    op=7 is accepted in one cycle, produces no wb_en, flags unchanged.
// STRUCTURE
//  - Package ex16b_pkg: WIDTH, RDW, opcode localparams (OP_ADD..OP_MUL), state encoding (ST_IDLE, ST_MUL).
//  - Sub-module ex16b_mul_seq: start/done shift-add multiplier with a 4-bit iteration counter and clear on rst.
//  - Top holds the ALU/shift logic, FSM and writeback registers.
// TESTING
//  1. ADD 0xFFFF+0x0001 rd=2 -> next cycle wb_en=1, wb_rd=2, wb_data=0x0000, Z=1, C=1.
//  2. SUB 0x0003-0x0005 -> wb_data=0xFFFE, Z=0, C=1; then SUB 5-3 -> 0x0002, C=0.
//  3. SHL 0x8001 by 1 -> 0x0002, C=1; SHR 0x0001 by 0 -> 0x0001, C=0.
//  4. Back-to-back AND/OR/XOR on 3 cycles -> 3 consecutive wb_en pulses, correct rd order.
//  5. MUL 0x0003*0x0005 rd=1 (MUL_EN) -> in_ready=0 for 16 cycles, wb_data=0x000F at N+17.
//     0x0100*0x0100 -> 0x0000, Z=1.
//  6. rst at MUL iteration 8 -> no wb_en, busy=0, in_ready=1 after reset.
//     Without EX16B_MUL_EN, op=7 -> accepted, no wb_en.

Source files
------------

// File: rtl/ex16b_pkg.sv
// Shared constants for the ex16b execute stage: widths, opcodes and FSM states.
package ex16b_pkg;

  localparam int unsigned Width    = 16;
  localparam int unsigned RdW      = 2;
  localparam int unsigned MulIters = 16;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpShl = 3'd5;
  localparam logic [2:0] OpShr = 3'd6;
  localparam logic [2:0] OpMul = 3'd7;

  typedef enum logic {StIdle, StMul} state_e;

endpackage

// File: rtl/ex16b_unit_mul_seq.sv
// Iterative shift-add multiplier (low Width bits). done_o is combinational on the last
// iteration so the caller can capture prod_o on the same edge that ends the sequence.
module ex16b_mul_seq
  import ex16b_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] prod_o
);

  localparam logic [3:0] LastIter = 4'(MulIters - 1);

  logic             run_q;
  logic [3:0]       cnt_q;
  logic [Width-1:0] acc_q, acc_d, mcand_q, mplier_q;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 4'd1;
      if (cnt_q == LastIter) run_q <= 1'b0;
    end
  end

  assign done_o = run_q && (cnt_q == LastIter);
  assign prod_o = acc_d;

endmodule

// File: rtl/ex16b_unit.sv
// Execute/writeback stage of the 16-bit datapath: ALU, shifter and optional iterative MUL.
// Define EX16B_MUL_EN to build the multiplier; otherwise op 7 is a one-cycle no-op.
module ex16b_unit
  import ex16b_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] opa_i,
  input  logic [Width-1:0] opb_i,
  input  logic [RdW-1:0]   rd_i,
  output logic             wb_en_o,
  output logic [RdW-1:0]   wb_rd_o,
  output logic [Width-1:0] wb_data_o,
  output logic             flag_z_o,
  output logic             flag_c_o,
  output logic             busy_o,
  inout  wire              dvdd_io,
  inout  wire              dgnd_io
);

  state_e           state_q;
  logic             accept;
  logic [Width:0]   ext_res;
  logic [Width-1:0] alu_res;
  logic             alu_c;
  logic             unused_supply;

  assign unused_supply = dvdd_io ^ dgnd_io;

  assign in_ready_o = (state_q == StIdle) && !rst_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    ext_res = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (op_i)
      OpAdd: begin
        ext_res = {1'b0, opa_i} + {1'b0, opb_i};
        {alu_c, alu_res} = ext_res;
      end
      OpSub: begin
        ext_res = {1'b0, opa_i} - {1'b0, opb_i};
        {alu_c, alu_res} = ext_res;
      end
      OpAnd: alu_res = opa_i & opb_i;
      OpOr:  alu_res = opa_i | opb_i;
      OpXor: alu_res = opa_i ^ opb_i;
      // Widened by one bit so the last bit shifted out lands in the carry slot.
      OpShl: begin
        ext_res = {1'b0, opa_i} << opb_i[3:0];
        {alu_c, alu_res} = ext_res;
      end
      OpShr: begin
        ext_res = {opa_i, 1'b0} >> opb_i[3:0];
        {alu_res, alu_c} = ext_res;
      end
      default: ;
    endcase
  end

`ifdef EX16B_MUL_EN
  logic             mul_done;
  logic [Width-1:0] mul_prod;
  logic [RdW-1:0]   mul_rd_q;

  ex16b_mul_seq u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (accept && (op_i == OpMul)),
    .a_i     (opa_i),
    .b_i     (opb_i),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  assign busy_o = (state_q == StMul);
`else
  assign busy_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      wb_en_o   <= 1'b0;
      wb_rd_o   <= '0;
      wb_data_o <= '0;
      flag_z_o  <= 1'b0;
      flag_c_o  <= 1'b0;
`ifdef EX16B_MUL_EN
      mul_rd_q  <= '0;
`endif
    end else begin
      wb_en_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (op_i == OpMul) begin
`ifdef EX16B_MUL_EN
              state_q  <= StMul;
              mul_rd_q <= rd_i;
`endif
            end else begin
              wb_en_o   <= 1'b1;
              wb_rd_o   <= rd_i;
              wb_data_o <= alu_res;
              flag_z_o  <= (alu_res == '0);
              flag_c_o  <= alu_c;
            end
          end
        end
        StMul: begin
`ifdef EX16B_MUL_EN
          if (mul_done) begin
            state_q   <= StIdle;
            wb_en_o   <= 1'b1;
            wb_rd_o   <= mul_rd_q;
            wb_data_o <= mul_prod;
            flag_z_o  <= (mul_prod == '0);
            flag_c_o  <= 1'b0;
          end
`else
          state_q <= StIdle;
`endif
        end
      endcase
    end
  end

endmodule
